// File: rtl/div_signfix_stage.sv
// div_signfix_stage: signed divider last stage with sign fix, saturation, divide-by-zero flag and 2-entry skid output
// Define DIVZERO_CNT_EN to add the saturating divide-by-zero event counter behind dz_count/cnt_clr.
module div_signfix_stage #(
  parameter int QW = 16,
  parameter int RW = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [QW-1:0]    quotient_in,
  input  logic [RW-1:0]    remainder_in,
  input  logic             neg_divisor_in,
  input  logic             neg_dividend_in,
  input  logic             divisor_no_cero_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    quotient_out,
  output logic [RW-1:0]    remainder_out,
  output logic             ovf_out,
  output logic             dz_out,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] dz_count
);
  typedef struct packed {
    logic [QW-1:0] q;
    logic [RW-1:0] r;
    logic          ovf;
    logic          dz;
  } payloadT;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} stateT;
  localparam logic [QW-1:0] qMax = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] qMin = {1'b1, {(QW-1){1'b0}}};
  stateT   state;
  payloadT mainP, skidP, newP;
  logic    inv, accept, pop;
  assign in_ready  = state != TWO;
  assign out_valid = state != EMPTY;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign {quotient_out, remainder_out, ovf_out, dz_out} = mainP;
  // A magnitude of exactly 2^(QW-1) is representable only when negated.
  always_comb begin
    inv      = neg_dividend_in ^ neg_divisor_in;
    newP.dz  = !divisor_no_cero_in;
    newP.ovf = divisor_no_cero_in & (inv ? quotient_in > qMin : quotient_in[QW-1]);
    newP.q   = !divisor_no_cero_in ? (neg_dividend_in ? qMin : qMax) :
               newP.ovf ? (inv ? qMin : qMax) : inv ? -quotient_in : quotient_in;
    newP.r   = !divisor_no_cero_in ? '0 : neg_dividend_in ? -remainder_in : remainder_in;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EMPTY;
      mainP <= '0;
      skidP <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          mainP <= newP;
          state <= ONE;
        end
        ONE: if (accept && pop) mainP <= newP;
        else if (accept) begin
          skidP <= newP;
          state <= TWO;
        end else if (pop) state <= EMPTY;
        TWO: if (pop) begin
          mainP <= skidP;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
`ifdef DIVZERO_CNT_EN
  logic [CNT_W-1:0] dzCnt;
  always_ff @(posedge clk) begin
    if (!reset || cnt_clr) dzCnt <= '0;
    else if (accept && !divisor_no_cero_in && !(&dzCnt)) dzCnt <= dzCnt + CNT_W'(1);
  end
  assign dz_count = dzCnt;
`else
  logic unusedCntClr;
  assign unusedCntClr = cnt_clr;
  assign dz_count     = '0;
`endif
endmodule

// File: tb/tb_div_signfix_stage.sv
// tb_div_signfix_stage: directed vectors plus scoreboard soak for the divider sign-fix stage.
module tb_div_signfix_stage;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, neg_divisor_in, neg_dividend_in, divisor_no_cero_in;
  logic out_valid, out_ready, ovf_out, dz_out, cnt_clr;
  logic [15:0] quotient_in, remainder_in, quotient_out, remainder_out;
  logic [1:0] dz_count;
  int passCnt = 0, totalCnt = 0, popCnt = 0;
  logic [33:0] sb[$];
  logic [33:0] got, want, prevOut;
  logic prevStall = 1'b0;

  typedef struct packed {
    logic [15:0] q, r;
    logic nd, nv, nz;
    logic [15:0] eq, er;
    logic eo, ed;
  } vecT;

  always #5 clk = ~clk;

  div_signfix_stage #(.QW(16), .RW(16), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .quotient_in(quotient_in), .remainder_in(remainder_in),
    .neg_divisor_in(neg_divisor_in), .neg_dividend_in(neg_dividend_in),
    .divisor_no_cero_in(divisor_no_cero_in), .out_valid(out_valid), .out_ready(out_ready),
    .quotient_out(quotient_out), .remainder_out(remainder_out), .ovf_out(ovf_out),
    .dz_out(dz_out), .cnt_clr(cnt_clr), .dz_count(dz_count)
  );

  function automatic logic [33:0] model(input logic [15:0] q, r, input logic nd, nv, nz);
    logic [15:0] eq, er;
    logic eo;
    if (!nz) return {nd ? 16'h8000 : 16'h7FFF, 16'h0, 1'b0, 1'b1};
    if (nd == nv) begin
      eo = q[15];
      eq = eo ? 16'h7FFF : q;
    end else begin
      eo = q > 16'h8000;
      eq = eo ? 16'h8000 : 16'h0 - q;
    end
    er = nd ? 16'h0 - r : r;
    return {eq, er, eo, 1'b0};
  endfunction

  // Inputs change just after posedge, so negedge sees exactly what the next edge will use.
  always @(negedge clk) begin
    got = {quotient_out, remainder_out, ovf_out, dz_out};
    if (!reset) begin
      sb.delete();
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        totalCnt++;
        if (got !== prevOut) $display("FAIL stall_hold: got %h required %h", got, prevOut);
        else passCnt++;
      end
      if (out_valid && out_ready) begin
        totalCnt++;
        popCnt++;
        if (sb.size() == 0) $display("FAIL sb_pop: got unexpected %h required no output", got);
        else begin
          want = sb.pop_front();
          if (got !== want) $display("FAIL sb_data: got %h required %h", got, want);
          else passCnt++;
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(quotient_in, remainder_in, neg_dividend_in, neg_divisor_in, divisor_no_cero_in));
      prevStall = out_valid && !out_ready;
      prevOut = got;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic [15:0] q, r, input logic nd, nv, nz);
    quotient_in = q;
    remainder_in = r;
    neg_dividend_in = nd;
    neg_divisor_in = nv;
    divisor_no_cero_in = nz;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [15:0] q, r, input logic nd, nv, nz);
    setIn(q, r, nd, nv, nz);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    setIn(16'h1234, 16'h5, 1'b1, 1'b0, 1'b0);
    repeat (2) tick;
    @(negedge clk);
    totalCnt++;
    if ({out_valid, in_ready, quotient_out, remainder_out, ovf_out, dz_out, dz_count} !== {1'b0, 1'b1, 36'h0})
      $display("FAIL reset_state: got v=%b rdy=%b q=%h r=%h ovf=%b dz=%b cnt=%0d required v=0 rdy=1 rest 0",
               out_valid, in_ready, quotient_out, remainder_out, ovf_out, dz_out, dz_count);
    else passCnt++;
    tick;
    reset = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_sign;
    vecT v[4] = '{
      '{16'd14, 16'd2, 1'b1, 1'b0, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0},
      '{16'd14, 16'd2, 1'b1, 1'b1, 1'b1, 16'h000E, 16'hFFFE, 1'b0, 1'b0},
      '{16'd14, 16'd2, 1'b0, 1'b1, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 1'b0},
      '{16'd0,  16'd0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0}};
    out_ready = 1'b1;
    foreach (v[i]) begin
      send(v[i].q, v[i].r, v[i].nd, v[i].nv, v[i].nz);
      @(negedge clk);
      totalCnt++;
      if ({out_valid, quotient_out, remainder_out, ovf_out, dz_out} !== {1'b1, v[i].eq, v[i].er, v[i].eo, v[i].ed})
        $display("FAIL sign[%0d]: got v=%b q=%h r=%h ovf=%b dz=%b required v=1 q=%h r=%h ovf=%b dz=%b", i,
                 out_valid, quotient_out, remainder_out, ovf_out, dz_out, v[i].eq, v[i].er, v[i].eo, v[i].ed);
      else passCnt++;
      tick;
    end
  endtask

  task automatic test_saturation;
    vecT v[5] = '{
      '{16'h8000, 16'd0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b0},
      '{16'h8000, 16'd0, 1'b0, 1'b1, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0},
      '{16'h8001, 16'd0, 1'b1, 1'b0, 1'b1, 16'h8000, 16'h0000, 1'b1, 1'b0},
      '{16'h7FFF, 16'd3, 1'b1, 1'b1, 1'b1, 16'h7FFF, 16'hFFFD, 1'b0, 1'b0},
      '{16'h7FFF, 16'd3, 1'b0, 1'b1, 1'b1, 16'h8001, 16'h0003, 1'b0, 1'b0}};
    out_ready = 1'b1;
    foreach (v[i]) begin
      send(v[i].q, v[i].r, v[i].nd, v[i].nv, v[i].nz);
      @(negedge clk);
      totalCnt++;
      if ({out_valid, quotient_out, remainder_out, ovf_out, dz_out} !== {1'b1, v[i].eq, v[i].er, v[i].eo, v[i].ed})
        $display("FAIL sat[%0d]: got v=%b q=%h r=%h ovf=%b dz=%b required v=1 q=%h r=%h ovf=%b dz=%b", i,
                 out_valid, quotient_out, remainder_out, ovf_out, dz_out, v[i].eq, v[i].er, v[i].eo, v[i].ed);
      else passCnt++;
      tick;
    end
  endtask

  task automatic test_divzero;
    vecT v[3] = '{
      '{16'h1234, 16'h55, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1},
      '{16'h1234, 16'h55, 1'b0, 1'b1, 1'b0, 16'h7FFF, 16'h0000, 1'b0, 1'b1},
      '{16'hFFFF, 16'h55, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1}};
    out_ready = 1'b1;
    foreach (v[i]) begin
      send(v[i].q, v[i].r, v[i].nd, v[i].nv, v[i].nz);
      @(negedge clk);
      totalCnt++;
      if ({out_valid, quotient_out, remainder_out, ovf_out, dz_out} !== {1'b1, v[i].eq, v[i].er, v[i].eo, v[i].ed})
        $display("FAIL dz[%0d]: got v=%b q=%h r=%h ovf=%b dz=%b required v=1 q=%h r=%h ovf=%b dz=%b", i,
                 out_valid, quotient_out, remainder_out, ovf_out, dz_out, v[i].eq, v[i].er, v[i].eo, v[i].ed);
      else passCnt++;
      tick;
    end
  endtask

  task automatic test_backpressure;
    logic acc;
    out_ready = 1'b0;
    setIn(16'd1, 16'd0, 1'b0, 1'b0, 1'b1);
    tick;
    setIn(16'd2, 16'd0, 1'b0, 1'b0, 1'b1);
    tick;
    setIn(16'd3, 16'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    totalCnt++;
    if (in_ready !== 1'b0 || quotient_out !== 16'd1)
      $display("FAIL bp_full: got rdy=%b q=%h required rdy=0 q=0001", in_ready, quotient_out);
    else passCnt++;
    repeat (3) tick;
    @(negedge clk);
    totalCnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL bp_hold: got rdy=%b v=%b required rdy=0 v=1", in_ready, out_valid);
    else passCnt++;
    tick;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      totalCnt++;
      if (out_valid !== 1'b1 || quotient_out !== 16'(i + 1))
        $display("FAIL bp_order[%0d]: got v=%b q=%h required v=1 q=%h", i, out_valid, quotient_out, 16'(i + 1));
      else passCnt++;
      acc = in_valid && in_ready;
      tick;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_no_dup: got v=%b q=%h required v=0", out_valid, quotient_out);
    else passCnt++;
    tick;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send(16'h10, 16'h1, 1'b0, 1'b0, 1'b1);
    send(16'h20, 16'h2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    totalCnt++;
    if (in_ready !== 1'b0) $display("FAIL mid_two: got rdy=%b required 0", in_ready);
    else passCnt++;
    tick;
    reset = 1'b0;
    setIn(16'h99, 16'h9, 1'b1, 1'b0, 1'b0);
    tick;
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    totalCnt++;
    if ({out_valid, in_ready, quotient_out, remainder_out, ovf_out, dz_out, dz_count} !== {1'b0, 1'b1, 36'h0})
      $display("FAIL mid_reset: got v=%b rdy=%b q=%h r=%h ovf=%b dz=%b cnt=%0d required v=0 rdy=1 rest 0",
               out_valid, in_ready, quotient_out, remainder_out, ovf_out, dz_out, dz_count);
    else passCnt++;
    tick;
    out_ready = 1'b1;
    send(16'h42, 16'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    totalCnt++;
    if (out_valid !== 1'b1 || quotient_out !== 16'h42)
      $display("FAIL mid_latency: got v=%b q=%h required v=1 q=0042", out_valid, quotient_out);
    else passCnt++;
    tick;
  endtask

  task automatic test_counter;
    logic [1:0] expCnt = 2'd0;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(16'h5, 16'h1, i[0], 1'b0, 1'b0);
`ifdef DIVZERO_CNT_EN
      expCnt = (expCnt == 2'd3) ? 2'd3 : expCnt + 2'd1;
`endif
      @(negedge clk);
      totalCnt++;
      if (dz_count !== expCnt) $display("FAIL cnt_inc[%0d]: got %0d required %0d", i, dz_count, expCnt);
      else passCnt++;
      tick;
    end
    setIn(16'h5, 16'h1, 1'b0, 1'b0, 1'b0);
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (dz_count !== 2'd0) $display("FAIL cnt_clr: got %0d required 0", dz_count);
    else passCnt++;
    tick;
  endtask

  task automatic test_soak;
    int startPops, waited;
    logic done, acc;
    startPops = popCnt;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            tick;
          end
          setIn($urandom_range(0, 3) == 0 ? 16'h8000 + 16'($urandom_range(0, 1)) : 16'($urandom),
                16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) != 0);
          waited = 0;
          do begin
            @(negedge clk);
            acc = in_ready;
            tick;
            waited++;
          end while (!acc && waited < 100);
          if (!acc) begin
            totalCnt++;
            $display("FAIL soak_accept_timeout: got in_ready=0 for 100 cycles required accept");
            break;
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom);
          tick;
        end
      end
    join
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (sb.size() != 0 || out_valid); k++) tick;
    totalCnt++;
    if (sb.size() != 0 || popCnt - startPops != 1000)
      $display("FAIL soak_drain: got pops=%0d left=%0d required pops=1000 left=0", popCnt - startPops, sb.size());
    else passCnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0;
    quotient_in = '0;
    remainder_in = '0;
    neg_divisor_in = 1'b0;
    neg_dividend_in = 1'b0;
    divisor_no_cero_in = 1'b1;
    test_reset;
    test_sign;
    test_saturation;
    test_divzero;
    test_backpressure;
    test_reset_mid;
    test_counter;
    test_soak;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
